hamming74_decoder_pipe: RTL and testbench

//  Pipelined single-error-correcting Hamming(7,4) decoder, downstream of the error-injection stage.

---
 rtl/hamming74_decoder_pipe_pkg.sv | 39 +++
 rtl/hamming74_syndrome.sv | 19 +
 rtl/hamming74_decoder_pipe.sv | 113 +++++++++++
 tb/tb_hamming74_decoder_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_decoder_pipe_pkg.sv
// Shared definitions for the Hamming(7,4) decoder slice.
// Codewords use position numbering [1:7] (p1 p2 d3 p4 d5 d6 d7), so
// code[1] is the MSB of a written literal. Syndromes are {s4,s2,s1}, and
// a nonzero syndrome names the codeword position to invert.
package hamming74_decoder_pipe_pkg;

   localparam int CODE_W = 7;
   localparam int SYN_W  = 3;
   localparam int DATA_W = 4;

   // Parity positions
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P4 = 4;

   // Data positions
   localparam int D3 = 3;
   localparam int D5 = 5;
   localparam int D6 = 6;
   localparam int D7 = 7;

   // Stage-1 payload: the received word plus its syndrome
   typedef struct packed {
      logic [1:CODE_W]    code;
      logic [SYN_W-1:0]   syn;
   } stage1_t;

   // One-hot mask selecting the codeword position named by the syndrome.
   // Position 1 is the MSB, so position n is the MSB shifted right by n-1.
   function automatic logic [1:CODE_W] flipMask(input logic [SYN_W-1:0] syn);
      flipMask = (syn == 3'd0) ? 7'd0 : (7'b1000000 >> (syn - 3'd1));
   endfunction

   // Pull {d3,d5,d6,d7} out of a codeword
   function automatic logic [DATA_W-1:0] extractData(input logic [1:CODE_W] code);
      extractData = {code[D3], code[D5], code[D6], code[D7]};
   endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome generator.
// Ports:
//   code_i      [1:7]  codeword, p1 p2 d3 p4 d5 d6 d7
//   syndrome_o  [2:0]  {s4,s2,s1}; nonzero value is the flipped position
module hamming74_syndrome
   import hamming74_decoder_pipe_pkg::*;
(
   input  logic [1:CODE_W]   code_i,
   output logic [SYN_W-1:0]  syndrome_o
);

   // Each parity bit covers the positions whose index has that bit set
   always_comb begin
      syndrome_o[0] = code_i[P1] ^ code_i[D3] ^ code_i[D5] ^ code_i[D7];
      syndrome_o[1] = code_i[P2] ^ code_i[D3] ^ code_i[D6] ^ code_i[D7];
      syndrome_o[2] = code_i[P4] ^ code_i[D5] ^ code_i[D6] ^ code_i[D7];
   end

endmodule

// File: rtl/hamming74_decoder_pipe.sv
// Two-stage pipelined Hamming(7,4) single-error-correcting decoder.
// Stage 1 captures the codeword and its syndrome; stage 2 holds the
// corrected data, syndrome and error flag. A saturating counter tallies
// delivered words that needed correction.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake for in_code [1:7]
//   out_valid/out_ready output handshake for out_data/out_syndrome/out_err
//   clr_count           synchronous clear of err_count (wins over increment)
//   err_count [CNT_W]   saturating count of delivered words with out_err=1
module hamming74_decoder_pipe
   import hamming74_decoder_pipe_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:CODE_W]     in_code,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [SYN_W-1:0]    out_syndrome,
   output logic                out_err,
   input  logic                clr_count,
   output logic [CNT_W-1:0]    err_count
);

   logic                s1Valid_q, s1Valid_d;
   stage1_t             s1_q, s1_d;
   logic                s2Valid_q, s2Valid_d;
   logic [DATA_W-1:0]   outData_q, outData_d;
   logic [SYN_W-1:0]    outSyn_q, outSyn_d;
   logic                outErr_q, outErr_d;
   logic [CNT_W-1:0]    errCount_q, errCount_d;
   logic [SYN_W-1:0]    inSyn;
   logic                adv2;
   logic                inReady;

   hamming74_syndrome u_syndrome (
      .code_i     (in_code),
      .syndrome_o (inSyn)
   );

   // Both stages advance together whenever the output slot is empty or
   // draining, so an empty stage never blocks the one behind it. Payload
   // registers only load on valid words to keep held outputs clean.
   always_comb begin
      adv2    = !s2Valid_q || out_ready;
      inReady = !s1Valid_q || adv2;

      s1Valid_d = s1Valid_q;
      s1_d      = s1_q;
      if (inReady) begin
         s1Valid_d = in_valid;
         if (in_valid) begin
            s1_d.code = in_code;
            s1_d.syn  = inSyn;
         end
      end

      s2Valid_d = s2Valid_q;
      outData_d = outData_q;
      outSyn_d  = outSyn_q;
      outErr_d  = outErr_q;
      if (adv2) begin
         s2Valid_d = s1Valid_q;
         if (s1Valid_q) begin
            outData_d = extractData(s1_q.code ^ flipMask(s1_q.syn));
            outSyn_d  = s1_q.syn;
            outErr_d  = |s1_q.syn;
         end
      end

      // Clear has priority; increment stops at all-ones
      errCount_d = errCount_q;
      if (clr_count) begin
         errCount_d = '0;
      end else if (s2Valid_q && out_ready && outErr_q && (errCount_q != '1)) begin
         errCount_d = errCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s1_q       <= '0;
         s2Valid_q  <= 1'b0;
         outData_q  <= '0;
         outSyn_q   <= '0;
         outErr_q   <= 1'b0;
         errCount_q <= '0;
      end else begin
         s1Valid_q  <= s1Valid_d;
         s1_q       <= s1_d;
         s2Valid_q  <= s2Valid_d;
         outData_q  <= outData_d;
         outSyn_q   <= outSyn_d;
         outErr_q   <= outErr_d;
         errCount_q <= errCount_d;
      end
   end

   assign in_ready     = inReady;
   assign out_valid    = s2Valid_q;
   assign out_data     = outData_q;
   assign out_syndrome = outSyn_q;
   assign out_err      = outErr_q;
   assign err_count    = errCount_q;

endmodule

// File: tb/tb_hamming74_decoder_pipe.sv
// Self-checking bench for hamming74_decoder_pipe. Two instances share all
// inputs: one with the default counter width, one with a 2-bit counter to
// exercise saturation. A queue-based reference decodes each accepted word.
module tb_hamming74_decoder_pipe;

   typedef struct {
      logic [3:0] data;
      logic [2:0] syn;
      logic       err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:7]  in_code = '0;
   logic        out_ready = 1'b0;
   logic        clr_count = 1'b0;
   logic        in_ready, out_valid, out_err;
   logic [3:0]  out_data;
   logic [2:0]  out_syndrome;
   logic [7:0]  err_count;
   logic        in_ready2, out_valid2, out_err2;
   logic [3:0]  out_data2;
   logic [2:0]  out_syndrome2;
   logic [1:0]  err_count2;

   int   errors = 0;
   int   checks = 0;
   exp_t expQ[$];
   int   modelCnt8 = 0;
   int   modelCnt2 = 0;
   logic       prevHold = 1'b0;
   logic [3:0] prevData;
   logic [2:0] prevSyn;
   logic       prevErr;

   hamming74_decoder_pipe #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_syndrome(out_syndrome), .out_err(out_err),
      .clr_count(clr_count), .err_count(err_count)
   );

   hamming74_decoder_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .out_syndrome(out_syndrome2), .out_err(out_err2),
      .clr_count(clr_count), .err_count(err_count2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:7] code);
      in_valid = valid;
      in_code  = code;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decoder: the syndrome of a Hamming code is the XOR of the
   // indices of all set positions
   function automatic exp_t modelDecode(input logic [1:7] c);
      exp_t e;
      int s;
      logic [1:7] f;
      s = 0;
      for (int p = 1; p <= 7; p++) if (c[p]) s = s ^ p;
      f = c;
      if (s != 0) f[s] = ~f[s];
      e.data = {f[3], f[5], f[6], f[7]};
      e.syn  = s[2:0];
      e.err  = (s != 0);
      return e;
   endfunction

   function automatic logic [1:7] encodeWord(input logic [3:0] d);
      logic [1:7] c;
      c = '0;
      c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
      c[1] = c[3] ^ c[5] ^ c[7];
      c[2] = c[3] ^ c[6] ^ c[7];
      c[4] = c[5] ^ c[6] ^ c[7];
      return c;
   endfunction

   // Per-cycle scoreboard, sampled mid-cycle while all handshakes are stable
   always @(negedge clk) begin
      if (!rst_n) begin
         expQ.delete();
         modelCnt8 = 0;
         modelCnt2 = 0;
         prevHold  = 1'b0;
         checkOutput("rstOutValid", out_valid, 0);
         checkOutput("rstCount", err_count, 0);
      end else begin
         exp_t e;
         checkOutput("errCount8", err_count, modelCnt8);
         checkOutput("errCount2", err_count2, modelCnt2);
         checkOutput("inReady", in_ready, (expQ.size() < 2) || out_ready);
         if (expQ.size() == 0) checkOutput("validEmpty", out_valid, 0);
         else if (expQ.size() == 2) checkOutput("validFull", out_valid, 1);
         if (prevHold)
            checkOutput("holdStable", {out_valid, out_syndrome, out_err, out_data},
                        {1'b1, prevSyn, prevErr, prevData});
         if (out_valid && out_ready && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("outWord", {out_syndrome, out_err, out_data}, {e.syn, e.err, e.data});
            if (!clr_count && e.err) begin
               if (modelCnt8 < 255) modelCnt8++;
               if (modelCnt2 < 3) modelCnt2++;
            end
         end
         if (clr_count) begin
            modelCnt8 = 0;
            modelCnt2 = 0;
         end
         if (in_valid && in_ready) expQ.push_back(modelDecode(in_code));
         prevHold = out_valid && !out_ready;
         prevData = out_data;
         prevSyn  = out_syndrome;
         prevErr  = out_err;
      end
   end

   initial begin
      logic [1:7] errWords [4];
      logic [2:0] errSyns  [4];
      logic [1:7] bpWords  [3];
      logic [3:0] got      [3];
      logic [3:0] heldData;
      int idx, n;
      errWords = '{7'b0100011, 7'b0110111, 7'b0110001, 7'b0110010};
      errSyns  = '{3'b011, 3'b101, 3'b110, 3'b111};
      bpWords  = '{encodeWord(4'h1), encodeWord(4'h2), encodeWord(4'h4)};

      // Reset state
      tick(); tick();
      checkOutput("resetValid", out_valid, 0);
      checkOutput("resetFields", {out_data, out_syndrome, out_err}, 0);
      checkOutput("resetErrCount", err_count, 0);
      rst_n = 1'b1;
      tick();

      // Clean word, two-cycle latency
      out_ready = 1'b1;
      applyStimulus(1'b1, 7'b0110011);
      tick();
      checkOutput("cleanLat1", out_valid, 0);
      applyStimulus(1'b0, '0);
      tick();
      checkOutput("cleanValid", out_valid, 1);
      checkOutput("cleanWord", {out_data, out_syndrome, out_err}, {4'b1011, 3'b000, 1'b0});
      tick();

      // Single-bit errors back to back
      for (int i = 0; i < 6; i++) begin
         if (i < 4) applyStimulus(1'b1, errWords[i]);
         else       applyStimulus(1'b0, '0);
         tick();
         if (i >= 1 && i <= 4) begin
            checkOutput("singleValid", out_valid, 1);
            checkOutput("singleWord", {out_data, out_syndrome, out_err},
                        {4'b1011, errSyns[i-1], 1'b1});
         end
      end
      checkOutput("singleCount8", err_count, 4);
      checkOutput("singleCount2", err_count2, 3);

      // Backpressure: only two words fit while the output is stalled
      out_ready = 1'b0;
      idx = 0;
      heldData = '0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (idx < 3) applyStimulus(1'b1, bpWords[idx]);
         else         applyStimulus(1'b0, '0);
         if (in_ready && idx < 3) idx++;
         tick();
         if (cyc == 2) heldData = out_data;
      end
      checkOutput("bpAccepted", idx, 2);
      checkOutput("bpInReady", in_ready, 0);
      checkOutput("bpHeld", {out_valid, out_data}, {1'b1, heldData});
      out_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (idx < 3) applyStimulus(1'b1, bpWords[idx]);
         else         applyStimulus(1'b0, '0);
         if (out_valid && n < 3) begin
            got[n] = out_data;
            n++;
         end
         if (in_valid && in_ready) idx++;
         tick();
      end
      checkOutput("bpCount", n, 3);
      checkOutput("bpOrder", {got[0], got[1], got[2]}, {4'h1, 4'h2, 4'h4});

      // Double error gets miscorrected
      applyStimulus(1'b1, 7'b0100111);
      tick();
      applyStimulus(1'b0, '0);
      tick();
      checkOutput("doubleWord", {out_valid, out_data, out_syndrome, out_err},
                  {1'b1, 4'b0101, 3'b110, 1'b1});
      tick();
      checkOutput("satCount8", err_count, 5);
      checkOutput("satCount2", err_count2, 3);

      // Clear coinciding with an error transfer
      applyStimulus(1'b1, 7'b0100011);
      tick();
      applyStimulus(1'b0, '0);
      tick();
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      checkOutput("clrWins8", err_count, 0);
      checkOutput("clrWins2", err_count2, 0);

      // Reset with both stages full
      out_ready = 1'b0;
      applyStimulus(1'b1, encodeWord(4'h9));
      tick();
      applyStimulus(1'b1, encodeWord(4'h6));
      tick();
      applyStimulus(1'b0, '0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", out_valid, 0);
      tick(); tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         tick();
         checkOutput("noStale", out_valid, 0);
      end
      applyStimulus(1'b1, encodeWord(4'hC));
      tick();
      applyStimulus(1'b0, '0);
      checkOutput("postRstLat1", out_valid, 0);
      tick();
      checkOutput("postRstWord", {out_valid, out_data, out_err}, {1'b1, 4'hC, 1'b0});
      tick();

      // Random traffic with 0, 1 or 2 flipped bits
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [1:7] c;
         int nf, pa, pb;
         c  = encodeWord(4'($urandom_range(0, 15)));
         nf = $urandom_range(0, 2);
         pa = $urandom_range(1, 7);
         pb = (pa % 7) + 1;
         if (nf >= 1) c[pa] = ~c[pa];
         if (nf == 2) c[pb] = ~c[pb];
         out_ready = ($urandom_range(0, 3) != 0);
         clr_count = ($urandom_range(0, 24) == 0);
         applyStimulus($urandom_range(0, 3) != 0, c);
         tick();
      end

      // Drain
      clr_count = 1'b0;
      out_ready = 1'b1;
      applyStimulus(1'b0, '0);
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (expQ.size() == 0 && !out_valid) break;
         tick();
      end
      tick();
      checkOutput("drainEmpty", expQ.size(), 0);
      checkOutput("drainValid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
